am2940_dma_seq: RTL and testbench
=================================

// Module: am2940_dma_seq
// PURPOSE
//  Sequencer driving one am2940 DMA address generator: accepts a transfer request, programs it
//  (control reg, address, word count), then steps its counters one word per memory ack until done.
//  Sits between the bus-master request logic and am2940 in the DMA subsystem.
// PARAMETERS
//  DATA_W       8   width of am2940 data bus, addresses and word counts
//  CR_W         3   control-register mode bits written from req_mode
//  TIMEOUT_CYC  16  idle cycles in RUN before abort (only with AM2940_SEQ_TIMEOUT_EN)
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       synchronous active-low reset
//  req_valid   in   1       request present; fields below valid while high
//  req_ready   out  1       seq accepts request; transfer on req_valid&req_ready
//  req_addr    in   DATA_W  start address
//  req_count   in   DATA_W  words to transfer
//  req_mode    in   CR_W    am2940 control-register mode
//  instr       out  3       am2940 instruction
//  dma_data    out  DATA_W  to am2940 datain during load states, else 0
//  cina, cinw  out  1       am2940 address/word counter advance enables (high = advance)
//  dma_done    in   1       am2940 done (word count exhausted)
//  mem_req     out  1       seq requests one word move at current am2940 address
//  mem_ack     in   1       word moved this cycle
//  busy        out  1       high in any state except IDLE
//  xfer_done   out  1       1-cycle pulse at end of transfer
//  xfer_err    out  1       1-cycle pulse with xfer_done when aborted (timeout)
// BEHAVIOUR
//  Reset (rst_n low at edge): state=IDLE; instr=I_RD_CR, dma_data=0, cina=cinw=0, mem_req=0,
//   busy=0, xfer_done=0, xfer_err=0, req_ready=1. Reset mid-transfer abandons it silently.
//  All outputs registered. States/transitions:
//   IDLE    req_ready=1; on accept latch addr/count/mode -> WR_CR (count==0 -> FINISH, no am2940 access)
//   WR_CR   instr=I_WR_CR, dma_data={0,mode}      -> LD_AD (1 cycle)
//   LD_AD   instr=I_LD_AD, dma_data=addr          -> LD_WC (1 cycle)
//   LD_WC   instr=I_LD_WC, dma_data=count         -> RUN   (1 cycle)
//   RUN     instr=I_EN_CT, mem_req=1; cina=cinw=mem_ack (combinational from mem_ack, same cycle);
//           internal word counter decrements per ack; on ack of last word (counter==1) -> FINISH;
//           dma_done high while counter>1 -> FINISH with xfer_err=1 (desync)
//   FINISH  xfer_done=1 for one cycle, instr=I_RD_CR, mem_req=0 -> IDLE
//  req_ready low in every non-IDLE state; new request only in IDLE (zero back-to-back overlap).
//  Latency accept->first mem_req: 4 cycles. Min transfer length in cycles: count+5.
//  Counter is DATA_W bits, no wrap: count 255 -> exactly 255 acks. mem_ack outside RUN ignored.
//  mem_ack and dma_done same cycle on last word: normal completion, xfer_err=0.
// CONFIGURATION
//  AM2940_SEQ_TIMEOUT_EN defined: RUN watchdog counts consecutive cycles without mem_ack; reaching
//   TIMEOUT_CYC -> FINISH with xfer_err=1, cina=cinw=0. Counter clears on every ack.
//  Undefined: no watchdog; RUN waits indefinitely for mem_ack; xfer_err only on desync.
// STRUCTURE
//  Package am2940_pkg: am2940 instruction enum (I_WR_CR=0, I_RD_CR=1, I_RD_WC=2, I_RD_AD=3,
//   I_REINIT=4, I_LD_AD=5, I_LD_WC=6, I_EN_CT=7) and seq state enum.
//  Single module; no sub-modules. Watchdog inline under the macro.
// TESTING
//  1 rst_n=0 two cycles mid-RUN -> next cycle IDLE, busy=0, mem_req=0, instr=1, req_ready=1.
//  2 req addr=8'h40 count=3 mode=3'b010, ack every cycle -> instr seq 0,5,6,7,7,7,1; dma_data
//    02,40,03; 3 cina/cinw pulses; xfer_done 8 cycles after accept.
//  3 count=0 -> no instr other than 1, xfer_done 2 cycles after accept, xfer_err=0.
//  4 count=4, ack every other cycle -> exactly 4 cina pulses, xfer_done after 4th ack.
//  5 count=5, dma_done forced after 2 acks -> xfer_done+xfer_err same cycle, back to IDLE.
//  6 TIMEOUT_EN, count=2, no ack -> xfer_err after 16 RUN cycles; without macro, busy stays high.

Source files
------------

// File: rtl/am2940_pkg.sv
// Shared am2940 types: the device instruction encoding and the DMA sequencer state set.
package am2940_pkg;

   typedef enum logic [2:0] {
      I_WR_CR  = 3'd0,
      I_RD_CR  = 3'd1,
      I_RD_WC  = 3'd2,
      I_RD_AD  = 3'd3,
      I_REINIT = 3'd4,
      I_LD_AD  = 3'd5,
      I_LD_WC  = 3'd6,
      I_EN_CT  = 3'd7
   } am2940_instr_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WR_CR  = 3'd1,
      S_LD_AD  = 3'd2,
      S_LD_WC  = 3'd3,
      S_RUN    = 3'd4,
      S_FINISH = 3'd5
   } seq_state_e;

endpackage

// File: rtl/am2940_dma_seq_if.sv
// Request, am2940 control and memory handshake bundle between bus-master logic and the sequencer.
interface am2940_dma_seq_if #(
   parameter int DATA_W = 8,
   parameter int CR_W   = 3
);
   logic              req_valid;
   logic              req_ready;
   logic [DATA_W-1:0] req_addr;
   logic [DATA_W-1:0] req_count;
   logic [CR_W-1:0]   req_mode;
   logic [2:0]        instr;
   logic [DATA_W-1:0] dma_data;
   logic              cina;
   logic              cinw;
   logic              dma_done;
   logic              mem_req;
   logic              mem_ack;
   logic              busy;
   logic              xfer_done;
   logic              xfer_err;

   modport slave (
      input  req_valid, req_addr, req_count, req_mode, dma_done, mem_ack,
      output req_ready, instr, dma_data, cina, cinw, mem_req, busy, xfer_done, xfer_err
   );

   modport master (
      output req_valid, req_addr, req_count, req_mode, dma_done, mem_ack,
      input  req_ready, instr, dma_data, cina, cinw, mem_req, busy, xfer_done, xfer_err
   );
endinterface

// File: rtl/am2940_dma_seq.sv
// Sequencer that programs one am2940 and steps it a word per memory ack.
// Optional RUN watchdog enabled by defining AM2940_SEQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// WR_CR  | writing mode into am2940 control register
// LD_AD  | loading start address
// LD_WC  | loading word count
// RUN    | counters enabled, one word moved per mem_ack
// FINISH | one-cycle completion pulse (with error flag on abort)
module am2940_dma_seq
   import am2940_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CR_W   = 3
`ifdef AM2940_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 16
`endif
) (
   input logic             clk,
   input logic             rst_n,
   am2940_dma_seq_if.slave bus
);

   seq_state_e        state_q, state_d;
   am2940_instr_e     instr_q, instr_d;
   logic [DATA_W-1:0] dma_data_q, dma_data_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wcnt_q, wcnt_d;
   logic [CR_W-1:0]   mode_q, mode_d;
   logic              mem_req_q, mem_req_d;
   logic              busy_q, busy_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

`ifdef AM2940_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
   logic [WD_W-1:0] wd_q, wd_d;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      mode_d  = mode_q;
      wcnt_d  = wcnt_q;
      err_d   = 1'b0;
`ifdef AM2940_SEQ_TIMEOUT_EN
      wd_d    = wd_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               mode_d  = bus.req_mode;
               wcnt_d  = bus.req_count;
               state_d = (bus.req_count == '0) ? S_FINISH : S_WR_CR;
            end
         end
         S_WR_CR: state_d = S_LD_AD;
         S_LD_AD: state_d = S_LD_WC;
         S_LD_WC: begin
            state_d = S_RUN;
`ifdef AM2940_SEQ_TIMEOUT_EN
            wd_d    = WD_LOAD;
`endif
         end
         S_RUN: begin
            if (bus.mem_ack) wcnt_d = wcnt_q - DATA_W'(1);
`ifdef AM2940_SEQ_TIMEOUT_EN
            if (bus.mem_ack)       wd_d = WD_LOAD;
            else if (wd_q != '0)   wd_d = wd_q - WD_W'(1);
`endif
            // Last-word ack wins over a simultaneous dma_done.
            if (bus.mem_ack && wcnt_q == DATA_W'(1)) begin
               state_d = S_FINISH;
            end else if (bus.dma_done && wcnt_q > DATA_W'(1)) begin
               state_d = S_FINISH;
               err_d   = 1'b1;
            end
`ifdef AM2940_SEQ_TIMEOUT_EN
            else if (!bus.mem_ack && wd_q == '0) begin
               state_d = S_FINISH;
               err_d   = 1'b1;
            end
`endif
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      instr_d    = I_RD_CR;
      dma_data_d = '0;
      mem_req_d  = 1'b0;
      busy_d     = 1'b1;
      ready_d    = 1'b0;
      done_d     = 1'b0;
      case (state_d)
         S_IDLE: begin
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
         S_WR_CR: begin
            instr_d    = I_WR_CR;
            dma_data_d = DATA_W'(mode_d);
         end
         S_LD_AD: begin
            instr_d    = I_LD_AD;
            dma_data_d = addr_d;
         end
         S_LD_WC: begin
            instr_d    = I_LD_WC;
            dma_data_d = wcnt_d;
         end
         S_RUN: begin
            instr_d   = I_EN_CT;
            mem_req_d = 1'b1;
         end
         S_FINISH: done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         instr_q    <= I_RD_CR;
         dma_data_q <= '0;
         addr_q     <= '0;
         mode_q     <= '0;
         wcnt_q     <= '0;
         mem_req_q  <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef AM2940_SEQ_TIMEOUT_EN
         wd_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         dma_data_q <= dma_data_d;
         addr_q     <= addr_d;
         mode_q     <= mode_d;
         wcnt_q     <= wcnt_d;
         mem_req_q  <= mem_req_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         err_q      <= err_d;
`ifdef AM2940_SEQ_TIMEOUT_EN
         wd_q       <= wd_d;
`endif
      end
   end

   // Counter advance tracks mem_ack in the same cycle, so it bypasses the output flops.
   assign bus.cina      = (state_q == S_RUN) && bus.mem_ack;
   assign bus.cinw      = (state_q == S_RUN) && bus.mem_ack;
   assign bus.instr     = instr_q;
   assign bus.dma_data  = dma_data_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.busy      = busy_q;
   assign bus.req_ready = ready_q;
   assign bus.xfer_done = done_q;
   assign bus.xfer_err  = err_q;

endmodule

// File: tb/tb_am2940_dma_seq.sv
// Scoreboard bench for am2940_dma_seq: stimulus queues expected loads and completions, a monitor checks them.
module tb_am2940_dma_seq;
   import am2940_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   am2940_dma_seq_if #(.DATA_W(8), .CR_W(3)) bus ();

   am2940_dma_seq #(.DATA_W(8), .CR_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [2:0] instr;
      logic [7:0] data;
   } load_t;

   typedef struct {
      logic err;
      int   lat;
      int   pulses;
   } done_t;

   load_t load_q[$];
   done_t done_q[$];

   int checks  = 0;
   int errors  = 0;
   int cyc     = 0;
   int acc_cyc = 0;
   int pulses  = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: runs on the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      load_t ld;
      done_t dn;
      if (!rst_n) begin
         pulses = 0;
      end else begin
         if (bus.req_valid && bus.req_ready) begin
            acc_cyc = cyc;
            pulses  = 0;
         end
         if (bus.busy) chk("req_ready_low_when_busy", int'(bus.req_ready), 0);
         if (bus.mem_ack || bus.cina || bus.cinw) begin
            chk("cina", int'(bus.cina), int'(bus.mem_req && bus.mem_ack));
            chk("cinw", int'(bus.cinw), int'(bus.mem_req && bus.mem_ack));
         end
         if (bus.cina) pulses++;
         if (bus.mem_req) chk("run_instr", int'(bus.instr), int'(I_EN_CT));
         if (bus.instr == I_WR_CR || bus.instr == I_LD_AD || bus.instr == I_LD_WC) begin
            checks++;
            if (load_q.size() == 0) begin
               errors++;
               $display("FAIL load_unexpected: got instr %0d data %02h expected none", bus.instr, bus.dma_data);
            end else begin
               ld = load_q.pop_front();
               if (bus.instr != ld.instr || bus.dma_data != ld.data) begin
                  errors++;
                  $display("FAIL load: got instr %0d data %02h expected instr %0d data %02h",
                           bus.instr, bus.dma_data, ld.instr, ld.data);
               end
            end
         end
         if (bus.xfer_err && !bus.xfer_done) chk("err_without_done", 1, 0);
         if (bus.xfer_done) begin
            if (done_q.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               dn = done_q.pop_front();
               chk("done_err", int'(bus.xfer_err), int'(dn.err));
               chk("done_latency", cyc - acc_cyc + 1, dn.lat);
               chk("done_pulses", pulses, dn.pulses);
            end
         end
      end
   end

   task automatic push_loads(input logic [7:0] addr, input logic [7:0] cnt, input logic [2:0] mode);
      load_q.push_back('{3'd0, {5'b0, mode}});
      load_q.push_back('{3'd5, addr});
      load_q.push_back('{3'd6, cnt});
   endtask

   task automatic issue(input logic [7:0] addr, input logic [7:0] cnt, input logic [2:0] mode);
      bus.req_addr  = addr;
      bus.req_count = cnt;
      bus.req_mode  = mode;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   // ack_pat: 0 every cycle (dma_done suppresses ack), 1 odd RUN cycles, 2 never, 3 every cycle always
   task automatic xfer(input logic [7:0] addr, input logic [7:0] cnt, input logic [2:0] mode,
                       input int ack_pat, input int done_at,
                       input logic exp_err, input int exp_lat, input int exp_pulses);
      int r   = 0;
      bit fin = 0;
      if (cnt != 0) push_loads(addr, cnt, mode);
      done_q.push_back('{exp_err, exp_lat, exp_pulses});
      issue(addr, cnt, mode);
      for (int k = 0; k < 400 && !fin; k++) begin
         if (bus.mem_req) begin
            r++;
            bus.mem_ack  = (ack_pat == 0 || ack_pat == 3) || (ack_pat == 1 && (r % 2) == 1);
            bus.dma_done = (done_at > 0 && r >= done_at);
            if (ack_pat == 0 && bus.dma_done) bus.mem_ack = 1'b0;
         end else begin
            bus.mem_ack  = 1'b0;
            bus.dma_done = 1'b0;
         end
         if (!bus.busy) fin = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      bus.mem_ack  = 1'b0;
      bus.dma_done = 1'b0;
      chk("xfer_completes_in_bound", int'(fin), 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"},      int'(bus.busy), 0);
      chk({tag, "_mem_req"},   int'(bus.mem_req), 0);
      chk({tag, "_instr"},     int'(bus.instr), 1);
      chk({tag, "_req_ready"}, int'(bus.req_ready), 1);
      chk({tag, "_dma_data"},  int'(bus.dma_data), 0);
      chk({tag, "_xfer_done"}, int'(bus.xfer_done), 0);
      chk({tag, "_xfer_err"},  int'(bus.xfer_err), 0);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_count = '0;
      bus.req_mode  = '0;
      bus.mem_ack   = 1'b0;
      bus.dma_done  = 1'b0;
      reset_pulse();
      check_idle_outputs("por");

      // Basic 3-word transfer, ack every cycle.
      xfer(8'h40, 8'd3, 3'b010, 0, 0, 1'b0, 8, 3);
      // Zero count skips the am2940 entirely.
      xfer(8'h55, 8'd0, 3'b111, 0, 0, 1'b0, 2, 0);
      // Ack every other cycle: RUN spans 7 cycles.
      xfer(8'h10, 8'd4, 3'b001, 1, 0, 1'b0, 12, 4);
      // dma_done raised after two acks of five: desync abort.
      xfer(8'h80, 8'd5, 3'b011, 0, 3, 1'b1, 8, 2);
      // Single word.
      xfer(8'hfe, 8'd1, 3'b100, 0, 0, 1'b0, 6, 1);
      // dma_done coincides with the last ack: normal completion.
      xfer(8'h33, 8'd2, 3'b101, 3, 2, 1'b0, 7, 2);
      // Full-scale count without wrap.
      xfer(8'h00, 8'd255, 3'b110, 0, 0, 1'b0, 260, 255);

      // mem_ack while idle must not advance anything.
      bus.mem_ack = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      bus.mem_ack = 1'b0;
      chk("idle_ack_busy", int'(bus.busy), 0);

      // Reset in the middle of RUN abandons the transfer.
      push_loads(8'h20, 8'd10, 3'b100);
      issue(8'h20, 8'd10, 3'b100);
      repeat (4) begin @(posedge clk); #1; end
      chk("pre_reset_mem_req", int'(bus.mem_req), 1);
      chk("pre_reset_busy", int'(bus.busy), 1);
      reset_pulse();
      check_idle_outputs("mid_run_reset");

`ifdef AM2940_SEQ_TIMEOUT_EN
      xfer(8'h44, 8'd2, 3'b000, 2, 0, 1'b1, 21, 0);
`else
      push_loads(8'h44, 8'd2, 3'b000);
      issue(8'h44, 8'd2, 3'b000);
      repeat (40) begin @(posedge clk); #1; end
      chk("no_watchdog_busy", int'(bus.busy), 1);
      chk("no_watchdog_mem_req", int'(bus.mem_req), 1);
      chk("no_watchdog_no_done", int'(bus.xfer_done), 0);
      reset_pulse();
      check_idle_outputs("hang_reset");
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("load_queue_drained", load_q.size(), 0);
      chk("done_queue_drained", done_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
